// File: rtl/rx_fifo_pkg.sv
// Shared defaults and sizing helpers for the receive-side character FIFO.
package rx_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 8;

  // Pointer width for a power-of-two depth; the occupancy count needs one more bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return int'($clog2(depth));
  endfunction

endpackage : rx_fifo_pkg

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of a level input.
// The history register resets to 1 so a level already high at reset release is ignored.
module rise_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic r_level_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_level_q <= 1'b1;
    end else begin
      r_level_q <= level;
    end
  end

  assign pulse = level & ~r_level_q;

endmodule : rise_edge_detect

// File: rtl/rx_char_fifo.sv
// Receive character FIFO between the serial deserializer and the CPU PIO.
// Show-ahead head byte, level-to-event push/pop, sticky overflow on dropped pushes.
module rx_char_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    charRecieved,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  input  logic                    clear_overflow,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    empty,
  output logic                    full,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    overflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic w_push_ev;
  logic w_pop_ev;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_empty;
  logic w_full;

  rise_edge_detect u_chr_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (charRecieved),
    .pulse   (w_push_ev)
  );

  rise_edge_detect u_pop_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (pop),
    .pulse   (w_pop_ev)
  );

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(DEPTH));

  // A push into a full FIFO is only taken when a pop frees the head in the same cycle.
  assign w_push_acc = w_push_ev & (~w_full | w_pop_ev);
  assign w_pop_acc  = w_pop_ev & ~w_empty;

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (w_push_acc) begin
      r_mem[r_wp] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push_acc) begin
        r_wp <= r_wp + PW'(1);
      end
      if (w_pop_acc) begin
        r_rp <= r_rp + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set takes priority over a concurrent clear so no drop goes unreported.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_push_ev & w_full & ~w_pop_ev) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign data_out = w_empty ? '0 : r_mem[r_rp];

endmodule : rx_char_fifo
